// File: rtl/hex_print_tx.sv
// hex_print_tx: serialises a print request into ASCII bytes on the UART
// transmit byte stream, then pulses ack_tx once.
//
// state | meaning
// IDLE  | waiting for req_tx; captures type/value and loads the first byte
// SEND  | presenting bytes on d_tx/vld_tx, advancing on each rdy_tx transfer
// ACK   | single-cycle ack_tx pulse
// HOLD  | request still held after ack; waiting for req_tx to drop
module hex_print_tx #(
  parameter bit HEX_UPPER = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_tx,
  input  logic        type_tx,
  input  logic [31:0] dout_tx,
  output logic        ack_tx,
  output logic [7:0]  d_tx,
  output logic        vld_tx,
  input  logic        rdy_tx
);

  typedef enum logic [1:0] {IDLE, SEND, ACK, HOLD} state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic [31:0] data, data_nxt;
  logic [7:0]  d_nxt;
  logic        vld_nxt, ack_nxt;
  logic [2:0]  cnt_dec;
  logic [3:0]  nib_next;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10)  return 8'h30 + {4'h0, n};
    else if (HEX_UPPER) return 8'h37 + {4'h0, n};
    else            return 8'h57 + {4'h0, n};
  endfunction

  // Counter value of the following digit is cnt-1; its nibble is latched[4i+3:4i].
  assign cnt_dec  = cnt - 3'd1;
  assign nib_next = data[{cnt_dec, 2'b00} +: 4];

  // State and all outputs are registered so vld_tx/ack_tx never see inputs combinationally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      cnt    <= 3'd0;
      data   <= 32'h0;
      d_tx   <= 8'h00;
      vld_tx <= 1'b0;
      ack_tx <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      data   <= data_nxt;
      d_tx   <= d_nxt;
      vld_tx <= vld_nxt;
      ack_tx <= ack_nxt;
    end
  end

  // Next-state and next-output decode; everything holds unless a case moves it.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    data_nxt  = data;
    d_nxt     = d_tx;
    vld_nxt   = vld_tx;
    ack_nxt   = 1'b0;
    case (state)
      IDLE: begin
        vld_nxt = 1'b0;
        if (req_tx) begin
          data_nxt  = dout_tx;
          vld_nxt   = 1'b1;
          state_nxt = SEND;
          if (type_tx) begin
            cnt_nxt = 3'd7;
            d_nxt   = hex_char(dout_tx[31:28]);
          end else begin
            cnt_nxt = 3'd0;
            d_nxt   = dout_tx[7:0];
          end
        end
      end
      SEND: begin
        if (rdy_tx) begin
          if (cnt != 3'd0) begin
            cnt_nxt = cnt_dec;
            d_nxt   = hex_char(nib_next);
          end else begin
            vld_nxt   = 1'b0;
            ack_nxt   = 1'b1;
            state_nxt = ACK;
          end
        end
      end
      ACK: begin
        state_nxt = req_tx ? HOLD : IDLE;
      end
      HOLD: begin
        if (!req_tx) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hex_print_tx.sv
// Directed bench for hex_print_tx: two instances (upper/lower case hex) share stimulus.
module tb_hex_print_tx;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_tx = 1'b0;
  logic        type_tx = 1'b0;
  logic [31:0] dout_tx = 32'h0;
  logic        rdy_tx = 1'b1;
  logic        ack_tx, vld_tx, ack_lc, vld_lc;
  logic [7:0]  d_tx, d_lc;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, ack_cnt = 0, both_err = 0, stall_err = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_d = 8'h00;
  logic [7:0] q[$], qlc[$];
  int         tq[$];
  int         lat, a0, stall;
  bit         got_ack;

  hex_print_tx dut (
    .clk(clk), .rstn(rstn), .req_tx(req_tx), .type_tx(type_tx), .dout_tx(dout_tx),
    .ack_tx(ack_tx), .d_tx(d_tx), .vld_tx(vld_tx), .rdy_tx(rdy_tx)
  );

  hex_print_tx #(.HEX_UPPER(1'b0)) dut_lc (
    .clk(clk), .rstn(rstn), .req_tx(req_tx), .type_tx(type_tx), .dout_tx(dout_tx),
    .ack_tx(ack_lc), .d_tx(d_lc), .vld_tx(vld_lc), .rdy_tx(rdy_tx)
  );

  always #5 clk = ~clk;

  // Record transferred bytes, acks and protocol violations at each active edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rstn) begin
      if (vld_tx && rdy_tx) begin
        q.push_back(d_tx);
        tq.push_back(cyc);
      end
      if (vld_lc && rdy_tx) qlc.push_back(d_lc);
      if (ack_tx) ack_cnt <= ack_cnt + 1;
      if (ack_tx && vld_tx) both_err <= both_err + 1;
      if (prev_stall && d_tx != prev_d) stall_err <= stall_err + 1;
    end
    prev_stall <= rstn && vld_tx && !rdy_tx;
    prev_d     <= d_tx;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q;
    q.delete();
    qlc.delete();
    tq.delete();
  endtask

  task automatic chk_stream(input string tag, input logic [63:0] exp, input int n, input bit lc);
    int sz;
    sz = lc ? qlc.size() : q.size();
    chk({tag, "_len"}, 32'(sz), 32'(n));
    for (int i = 0; i < n && i < sz; i++)
      chk(tag, 32'(lc ? qlc[i] : q[i]), 32'(exp[8*(n-1-i) +: 8]));
  endtask

  task automatic run_req(input logic t, input logic [31:0] v, input int hold,
                         input bit scramble, output int l);
    req_tx = 1'b1;
    type_tx = t;
    dout_tx = v;
    l = 0;
    for (int n = 1; n <= 200; n++) begin
      tick;
      if (scramble) begin
        dout_tx = $urandom;
        type_tx = 1'($urandom_range(0, 1));
      end
      if (n == 1) chk("first_vld", 32'(vld_tx), 32'd1);
      if (ack_tx) begin
        l = n;
        break;
      end
    end
    chk("ack_seen", 32'(ack_tx), 32'd1);
    for (int h = 0; h < hold; h++) tick;
    req_tx = 1'b0;
    tick;
  endtask

  initial begin
    rstn = 1'b0;
    repeat (3) tick;
    chk("rst_vld", 32'(vld_tx), 32'd0);
    chk("rst_ack", 32'(ack_tx), 32'd0);
    chk("rst_d", 32'(d_tx), 32'h00);
    rstn = 1'b1;
    tick;

    // single character
    clear_q;
    run_req(1'b0, 32'h0000_0050, 0, 1'b0, lat);
    chk("char_lat", 32'(lat), 32'd2);
    chk_stream("char", 64'h50, 1, 1'b0);
    chk("char_acks", 32'(ack_cnt), 32'd1);
    chk("char_ack_low", 32'(ack_tx), 32'd0);

    // hex word, both cases, back-to-back bytes
    clear_q;
    run_req(1'b1, 32'h1234_ABCD, 0, 1'b0, lat);
    chk("hex_lat", 32'(lat), 32'd9);
    chk_stream("hex_up", 64'h3132_3334_4142_4344, 8, 1'b0);
    chk_stream("hex_lc", 64'h3132_3334_6162_6364, 8, 1'b1);
    if (tq.size() == 8) chk("hex_gap", 32'(tq[7] - tq[0]), 32'd7);
    else chk("hex_gap_len", 32'(tq.size()), 32'd8);

    // backpressure
    clear_q;
    req_tx = 1'b1; type_tx = 1'b1; dout_tx = 32'hDEAD_BEEF;
    stall = 0; got_ack = 1'b0;
    for (int n = 0; n < 300 && !got_ack; n++) begin
      tick;
      if (ack_tx) got_ack = 1'b1;
      else if (q.size() >= 3 && stall < 5) begin
        rdy_tx = 1'b0;
        stall++;
      end else if (stall >= 5) rdy_tx = 1'($urandom_range(0, 1));
    end
    chk("bp_ack", 32'(ack_tx), 32'd1);
    req_tx = 1'b0; rdy_tx = 1'b1;
    tick;
    chk_stream("bp", 64'h4445_4144_4245_4546, 8, 1'b0);
    chk("bp_stable", 32'(stall_err), 32'd0);

    // held request, then a one-cycle drop and a new type 0 request
    clear_q;
    a0 = ack_cnt;
    run_req(1'b1, 32'h0000_0009, 4, 1'b0, lat);
    chk_stream("held", 64'h3030_3030_3030_3039, 8, 1'b0);
    chk("held_acks", 32'(ack_cnt), 32'(a0 + 1));
    clear_q;
    run_req(1'b0, 32'h0000_000A, 0, 1'b0, lat);
    chk_stream("rereq", 64'h0A, 1, 1'b0);
    chk("rereq_acks", 32'(ack_cnt), 32'(a0 + 2));

    // boundary values, inputs scrambled during SEND
    clear_q;
    run_req(1'b1, 32'h0000_0000, 0, 1'b1, lat);
    chk("zero_lat", 32'(lat), 32'd9);
    chk_stream("zero", 64'h3030_3030_3030_3030, 8, 1'b0);
    clear_q;
    run_req(1'b1, 32'hFFFF_FFFF, 0, 1'b1, lat);
    chk_stream("ones", 64'h4646_4646_4646_4646, 8, 1'b0);

    // reset mid-stream
    clear_q;
    a0 = ack_cnt;
    req_tx = 1'b1; type_tx = 1'b1; dout_tx = 32'h1234_5678;
    for (int n = 0; n < 20 && q.size() < 3; n++) tick;
    rstn = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(vld_tx), 32'd0);
    chk("mid_rst_ack", 32'(ack_tx), 32'd0);
    chk("mid_rst_d", 32'(d_tx), 32'h00);
    req_tx = 1'b0;
    tick; tick;
    rstn = 1'b1;
    tick; tick;
    chk("mid_rst_noack", 32'(ack_cnt), 32'(a0));
    chk("mid_rst_len", 32'(q.size()), 32'd3);
    clear_q;
    run_req(1'b1, 32'h1234_5678, 0, 1'b0, lat);
    chk_stream("post_rst", 64'h3132_3334_3536_3738, 8, 1'b0);

    chk("vld_ack_overlap", 32'(both_err), 32'd0);
    chk("stall_stable", 32'(stall_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
